// File: rtl/down_cnt_chain_load_pkg.sv
// rtl/down_cnt_chain_load_pkg.sv - shared types and helpers for the cascaded down-counter
//
// Contents:
//   state_t      one-shot timer FSM state (ST_IDLE, ST_RUN)
//   clamp_digit  limits a load value to the digit range 0..modulo-1
package down_cnt_chain_load_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Evaluated at 32 bits so a single helper serves every digit width;
    // callers truncate the result back to their digit width.
    function automatic logic [31:0] clamp_digit(input logic [31:0] value,
                                                 input logic [31:0] modulo);
        logic [31:0] max_val;
        max_val = modulo - 32'd1;
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/down_cnt_mod_load.sv
// rtl/down_cnt_mod_load.sv - single modulo-MODULO down-counting digit with clamped parallel load
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset, clears the digit to 0
//   ce            decrement request for this digit (already chain-qualified)
//   load          parallel load strobe, wins over ce
//   ld_data       load value, clamped to MODULO-1
//   hold_at_zero  when set, a decrement at 0 holds instead of wrapping
//   q             current digit value
//   zero          q == 0
module down_cnt_mod_load
    import down_cnt_chain_load_pkg::*;
#(
    parameter int MODULO = 10,
    parameter int W      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         load,
    input  logic [W-1:0] ld_data,
    input  logic         hold_at_zero,
    output logic [W-1:0] q,
    output logic         zero
);

    localparam logic [W-1:0] MAX_VAL = W'(MODULO - 1);

    logic [W-1:0] ld_clamped;

    assign ld_clamped = W'(clamp_digit(32'(ld_data), 32'(MODULO)));
    assign zero       = (q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= ld_clamped;
        end else if (ce) begin
            if (zero) begin
                if (!hold_at_zero) begin
                    q <= MAX_VAL;
                end
            end else begin
                q <= q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/down_cnt_chain_load.sv
// rtl/down_cnt_chain_load.sv - cascaded multi-digit modulo down-counter with load, borrow-out and one-shot timer
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   ce       count-enable pulse (one decrement request)
//   load     parallel load strobe (priority over start and ce)
//   ld_data  load value, digit i at [i*W +: W]
//   oneshot  0 = free-run wrap, 1 = one-shot timer
//   start    arms the one-shot timer (ignored when oneshot=0)
//   q        current count, same packing as ld_data
//   zero     all digits zero
//   bo       borrow-out, ce & run_en & zero
//   busy     timer armed
//   done     one-cycle pulse after the expiring edge
module down_cnt_chain_load
    import down_cnt_chain_load_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int MODULO = 10,
    parameter int W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic                load,
    input  logic [DIGITS*W-1:0] ld_data,
    input  logic                oneshot,
    input  logic                start,
    output logic [DIGITS*W-1:0] q,
    output logic                zero,
    output logic                bo,
    output logic                busy,
    output logic                done
);

    state_t              state;
    logic                run_en;
    logic                ce_cnt;
    logic                hold_at_zero;
    logic [DIGITS-1:0]   dig_zero;
    logic [DIGITS-1:0]   ce_dig;

    assign run_en       = oneshot ? (state == ST_RUN) : 1'b1;
    assign ce_cnt       = ce & run_en;
    assign zero         = &dig_zero;
    assign bo           = ce_cnt & zero;
    assign busy         = (state == ST_RUN);
    // One-shot expiry parks the count at zero; lower digits that are zero
    // under a nonzero upper digit must still wrap, hence the global zero term.
    assign hold_at_zero = oneshot & zero;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        // A digit decrements only when every lower digit is about to wrap.
        if (i == 0) begin : g_lsd
            assign ce_dig[i] = ce_cnt;
        end else begin : g_upper
            assign ce_dig[i] = ce_cnt & (&dig_zero[i-1:0]);
        end

        down_cnt_mod_load #(
            .MODULO (MODULO),
            .W      (W)
        ) u_digit (
            .clk          (clk),
            .rst_n        (rst_n),
            .ce           (ce_dig[i]),
            .load         (load),
            .ld_data      (ld_data[i*W +: W]),
            .hold_at_zero (hold_at_zero),
            .q            (q[i*W +: W]),
            .zero         (dig_zero[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!oneshot) begin
                state <= ST_IDLE;
            end else if (load) begin
                // Load reloads the count but leaves the timer state alone,
                // which also cancels an expiry landing in the same cycle.
                state <= state;
            end else if (state == ST_IDLE) begin
                if (start) begin
                    state <= ST_RUN;
                end
            end else if (ce && zero) begin
                state <= ST_IDLE;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/down_cnt_chain_load.md
# down_cnt_chain_load

Cascaded multi-digit modulo down-counter with parallel load, borrow-out and a one-shot timer mode. It is the decrementing counterpart of the single-digit modulo up-counter used in the synth's timing and parameter-editing paths. Typical uses are note-length and envelope-segment countdowns, and decrementing BCD-style values driven by UI "minus" events. Each digit is a modulo-MODULO down counter. A digit borrows from the next digit up when it wraps.

## Interface
Parameters:
- DIGITS, 4, number of cascaded digits (≥1)
- MODULO, 10, modulus of every digit (2..2**W)
- W, 4, bit width of one digit

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- ce  in  1  count-enable pulse (one decrement request)
- load  in  1  parallel load strobe
- ld_data  in  DIGITS*W  load value; digit i at bits [i*W +: W], digit 0 least significant
- oneshot  in  1  0 = free-run wrap mode, 1 = one-shot timer mode
- start  in  1  arm the one-shot timer (ignored when oneshot=0)
- q  out  DIGITS*W  current count, same packing as ld_data
- zero  out  1  all digits equal 0 (combinational from q)
- bo  out  1  borrow-out: combinational, = ce & run_en & zero
- busy  out  1  one-shot timer armed (state RUN)
- done  out  1  registered one-cycle pulse at one-shot expiry

## Operation
- run_en = oneshot ? (state==RUN) : 1.
- Digit i decrement enable: ce_i = ce & run_en & (digits 0..i-1 all zero). ce_0 = ce & run_en.
- On ce_i:
  - A digit at 0 becomes MODULO-1.
  - Any other digit decrements by 1.
- Load clamp: a digit with ld_data > MODULO-1 is loaded as MODULO-1. All other digits load exactly as given.
- Priority each cycle is load > start > ce.
  - load updates q and does not change state.
  - A ce in the same cycle as load is ignored.
- FSM, with states IDLE and RUN, used only when oneshot=1:
  - IDLE: q holds against ce. start moves to RUN.
  - RUN:
    - ce with zero=0 decrements normally.
    - ce with zero=1 does not wrap; q stays 0. State goes to IDLE and done is set for the next cycle.
    - start while in RUN is ignored.
  - Timer length: loading N and then starting gives expiry on the (N+1)-th ce.
- If oneshot changes to 0, the state is forced to IDLE on the next edge and done stays 0.
- Free-run mode (oneshot=0): all-zero plus ce wraps every digit to MODULO-1 and asserts bo in that cycle.
- Arithmetic: digit compares use W-bit unsigned values. MODULO-1 is computed at W bits. No value outside 0..MODULO-1 can ever be stored.

## Timing
- Reset values:
  - q = 0
  - state = IDLE
  - busy = 0
  - done = 0
  - zero = 1
  - bo = 0 (except that bo = ce when oneshot=0)
- Asserting rst_n mid-count clears everything immediately, without a clock edge. Counting resumes on the first edge after release.
- Latency:
  - q reflects load or ce on the edge of the same cycle (1 cycle).
  - bo and zero are combinational, with no added latency.
  - busy rises the cycle after start.
  - done is high for exactly the one cycle following the expiring edge, and busy is low in that same cycle.
- A borrow ripples through all DIGITS within one cycle, with no pipeline.
- If load and the expiring ce happen together, load wins: no expiry, and the count is reloaded.

## Structure
- Shared package: state enum (IDLE, RUN) and a function clamp_digit(value, MODULO).
- One sub-module, down_cnt_mod_load: a single digit with inputs clk, rst_n, ce, load, ld_data, hold_at_zero, and outputs q, zero.
  - The top instantiates it DIGITS times with a generate loop and builds the zero-prefix chain for the ce_i enables.
  - The top also holds the FSM.

## Test plan
All scenarios use DIGITS=2, MODULO=10, W=4.
- Load 0x23, oneshot=0, 24 ce pulses: q steps through 23, 22, …, 10, 09, …, 00, then wraps to 99. bo is high only on the ce at 00.
- Load 0xFA: q = 0x99 after the clamp. Load 0x5C: q = 0x59.
- oneshot=1, load 0x03, start, then 4 ce pulses:
  - q goes 03, 02, 01, 00, then stays 00.
  - done pulses once, one cycle after the 4th ce.
  - busy falls in that same cycle.
- oneshot=1 in IDLE, 5 ce pulses without start: q unchanged and done=0. A start while in RUN is ignored.
- Load and ce in the same cycle at q=0x10: q = the new ld_data with no decrement. Load with the expiring ce: done is never asserted.
- rst_n pulsed low asynchronously mid-run at q=0x47:
  - q = 0, busy = 0 and done = 0 immediately.
  - The first ce after release with oneshot=0 gives q = 0x99.
